alu_flag_unit: RTL and testbench
================================

// Module: alu_flag_unit
// PURPOSE
//  Execute-stage ALU that produces ALUResult and NZCV ALUFlags for the condition unit.
//  Flags use the bit order {N,Z,C,V} = ALUFlags[3:0]. The condition unit captures these
//  into its flag register (gated by FlagWriteE & CondEx).
//  Single-cycle ops: registered, latency 1. MUL: iterative shift-add, the unit is busy
//  for WIDTH cycles; the hazard logic stalls on ~ready.
// PARAMETERS
//  WIDTH      32    operand/result width (>=4)
//  CNT_W      6     iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      synchronous, active-high
//  start       in   1      operands valid; accepted only when ready=1
//  ALUControl  in   3      000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 11x reserved
//  SrcA        in   WIDTH  operand A
//  SrcB        in   WIDTH  operand B
//  ready       out  1      1 = idle, can accept start
//  done        out  1      1-cycle pulse: ALUResult/ALUFlags updated this cycle
//  ALUResult   out  WIDTH  registered result; held until next done
//  ALUFlags    out  4      registered {N,Z,C,V}; held until next done
// BEHAVIOUR
//  Reset: state=IDLE; ready=1; done=0; ALUResult=0; ALUFlags=4'b0000; counter and accumulator=0.
//  Reset mid-MUL: aborts the operation. No done pulse. Outputs take their reset values.
//  FSM IDLE:
//   - start & non-MUL: at the next edge, register the result and flags; done=1 for 1 cycle.
//     Stay in IDLE; ready stays 1, so back-to-back issue every cycle is allowed.
//   - start & MUL: latch A into multiplicand and B into multiplier; acc=0; cnt=0; go to MULT;
//     ready=0 from the next cycle.
//  FSM MULT, once per cycle:
//   - if mult[0]: acc += mcand (mod 2**WIDTH).
//   - Then mcand <<= 1, mult >>= 1, cnt++.
//   - When cnt==WIDTH-1 (the last step), register the low WIDTH bits; done=1; go to IDLE.
//   - Total latency: WIDTH cycles from the accepting edge to done (32 for the default).
//  start while ready=0: ignored. No queueing and no error indication.
//  ADD: {C,sum} = A+B (WIDTH+1 bits). V = (A[msb]==B[msb]) & (sum[msb]!=A[msb]).
//  SUB: {C,res} = A+~B+1, so C=1 means no borrow. V = (A[msb]!=B[msb]) & (res[msb]!=A[msb]).
//  AND/ORR/EOR: C=0, V=0.
//  MUL: N and Z from the low WIDTH bits. C and V are held at their previous ALUFlags values.
//  N = result[msb] and Z = (result==0) for all ops.
//  Reserved ALUControl 110/111: done pulses; ALUResult=0; ALUFlags held unchanged.
//  Outputs come only from registers; no combinational path from input to output.
//  Operands are sampled only on the accepting edge; later SrcA/SrcB changes do not affect an op in flight.
// STRUCTURE
//  Shared package alu_pkg:
//   - alu_op_t enum {ADD,SUB,AND,ORR,EOR,MUL} with the encodings above.
//   - FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0 bit-index constants (also used by condcheck).
//  One sub-module: alu_flag_gen, combinational. Inputs: op, A, B, result, carry.
//  Output: next {N,Z,C,V} plus a hold_cv qualifier. Shared by the single-cycle path and the MUL path.
//  The FSM, counter and MUL datapath stay in alu_flag_unit.
// TESTING
//  1 ADD 0x7FFFFFFF+0x00000001 -> after 1 cycle: done=1, ALUResult=0x80000000, ALUFlags=4'b1001 (N,V).
//  2 SUB 5-5 -> ALUResult=0, ALUFlags=4'b0110 (Z,C). SUB 3-5 -> 0xFFFFFFFE, ALUFlags=4'b1000.
//  3 ORR 0xF0F0_0000|0x0000_0F0F after an ADD that set C=1 -> 0xF0F00F0F, ALUFlags=4'b1000 (C,V cleared).
//  4 SUB 5-5 (ALUFlags=0110), then MUL 0x0000_1234*0x0000_0010 -> ready=0 for 32 cycles; start pulses
//    during that window are ignored; done on the 32nd cycle with 0x00012340, ALUFlags=4'b0010 (C held from SUB).
//  5 Reset asserted at cycle 10 of a MUL -> next cycle: ready=1, done=0, ALUResult=0, ALUFlags=0.
//    No late done pulse after reset.
//  6 Back-to-back ADD, AND, SUB on 3 consecutive starts -> 3 consecutive done pulses, each with correct
//    result/flags. Reserved op 3'b111 -> done, ALUResult=0, flags unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and FSM states.
// Imported by the execute-stage ALU and the condition checker.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    ORR = 3'b011,
    EOR = 3'b100,
    MUL = 3'b101
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MULT = 1'b1
  } alu_state_t;

  function automatic logic is_rsv_op(
    input logic [2:0] op
  );
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational NZCV generator shared by the
// single-cycle path and the multiplier finish step.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  output logic [3:0]       flags,
  output logic             hold_cv
);

  localparam int MSB = WIDTH - 1;

  logic a_s;
  logic b_s;
  logic r_s;

  assign a_s = a[MSB];
  assign b_s = b[MSB];
  assign r_s = result[MSB];

  always_comb begin
    flags   = '0;
    hold_cv = 1'b0;
    flags[FLAG_N] = r_s;
    flags[FLAG_Z] = (result == '0);
    unique case (1'b1)
      (op == ADD): begin
        flags[FLAG_C] = carry;
        flags[FLAG_V] = (a_s == b_s)
                      & (r_s != a_s);
      end
      (op == SUB): begin
        flags[FLAG_C] = carry;
        flags[FLAG_V] = (a_s != b_s)
                      & (r_s != a_s);
      end
      // product overflow is not tracked; keep prior C/V
      (op == MUL): hold_cv = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_flag_unit.sv
// Execute-stage ALU: registered single-cycle ops plus an
// iterative shift-add multiplier, producing NZCV flags.
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  alu_state_t       state_q;
  alu_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mult_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flags_q;
  logic             done_q;

  logic accept;
  logic is_mul;
  logic is_rsv;
  logic in_mult;
  logic last_step;

  assign in_mult   = (state_q == MULT);
  assign accept    = start & ~in_mult;
  assign is_mul    = (ALUControl == MUL);
  assign is_rsv    = is_rsv_op(ALUControl);
  assign last_step = in_mult & (cnt_q == LAST);

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic [WIDTH-1:0] acc_nxt;

  assign add_w = {1'b0, SrcA} + {1'b0, SrcB};
  // A + ~B + 1 so that C=1 means no borrow
  assign sub_w = {1'b0, SrcA} + {1'b0, ~SrcB}
               + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    unique case (1'b1)
      (ALUControl == ADD): begin
        sc_res   = add_w[WIDTH-1:0];
        sc_carry = add_w[WIDTH];
      end
      (ALUControl == SUB): begin
        sc_res   = sub_w[WIDTH-1:0];
        sc_carry = sub_w[WIDTH];
      end
      (ALUControl == AND): sc_res = SrcA & SrcB;
      (ALUControl == ORR): sc_res = SrcA | SrcB;
      (ALUControl == EOR): sc_res = SrcA ^ SrcB;
      default: ;
    endcase
  end

  assign acc_nxt = acc_q
                 + (mult_q[0] ? mcand_q : '0);

  logic [2:0]       gen_op;
  logic [WIDTH-1:0] gen_res;
  logic [3:0]       gen_flags;
  logic             gen_hold;
  logic [3:0]       flags_nxt;

  assign gen_op  = in_mult ? 3'(MUL) : ALUControl;
  assign gen_res = in_mult ? acc_nxt : sc_res;

  alu_flag_gen #(
    .WIDTH(WIDTH)
  ) u_flag_gen (
    .op      (gen_op),
    .a       (SrcA),
    .b       (SrcB),
    .result  (gen_res),
    .carry   (sc_carry),
    .flags   (gen_flags),
    .hold_cv (gen_hold)
  );

  always_comb begin
    flags_nxt = gen_flags;
    if (gen_hold) begin
      flags_nxt[FLAG_C] = flags_q[FLAG_C];
      flags_nxt[FLAG_V] = flags_q[FLAG_V];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept & is_mul) state_d = MULT;
      MULT: if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mult_q  <= '0;
      res_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (!in_mult) begin
        if (accept && is_mul) begin
          mcand_q <= SrcA;
          mult_q  <= SrcB;
          acc_q   <= '0;
          cnt_q   <= '0;
        end else if (accept) begin
          done_q <= 1'b1;
          res_q  <= sc_res;
          if (!is_rsv) flags_q <= flags_nxt;
        end
      end else begin
        acc_q   <= acc_nxt;
        mcand_q <= mcand_q << 1;
        mult_q  <= mult_q >> 1;
        cnt_q   <= cnt_q + 1'b1;
        if (last_step) begin
          done_q  <= 1'b1;
          res_q   <= acc_nxt;
          flags_q <= flags_nxt;
        end
      end
    end
  end

  assign ready     = ~in_mult;
  assign done      = done_q;
  assign ALUResult = res_q;
  assign ALUFlags  = flags_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed plus randomized bench for alu_flag_unit,
// checked against an arithmetic reference model.
module tb_alu_flag_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   ctl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] res;
  logic [3:0]   fl;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] m_res;
  logic [3:0]   m_fl;

  always #5 clk = ~clk;

  alu_flag_unit #(
    .WIDTH(W),
    .CNT_W(6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUControl (ctl),
    .SrcA       (a),
    .SrcB       (b),
    .ready      (ready),
    .done       (done),
    .ALUResult  (res),
    .ALUFlags   (fl)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  task automatic model(
    input logic [2:0]   op,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    longint      sx;
    longint      sy;
    longint      s;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      3'd0: begin
        u = 64'(x) + 64'(y);
        m_res = u[W-1:0];
        s = sx + sy;
        m_fl[1] = u[W];
        m_fl[0] = (s > 64'sd2147483647)
               || (s < -64'sd2147483648);
      end
      3'd1: begin
        m_res = x - y;
        s = sx - sy;
        m_fl[1] = (x >= y);
        m_fl[0] = (s > 64'sd2147483647)
               || (s < -64'sd2147483648);
      end
      3'd2: begin
        m_res = x & y; m_fl[1:0] = 2'b00;
      end
      3'd3: begin
        m_res = x | y; m_fl[1:0] = 2'b00;
      end
      3'd4: begin
        m_res = x ^ y; m_fl[1:0] = 2'b00;
      end
      3'd5: begin
        u = 64'(x) * 64'(y);
        m_res = u[W-1:0];
      end
      default: m_res = '0;
    endcase
    if (op < 3'd6) begin
      m_fl[3] = m_res[W-1];
      m_fl[2] = (m_res == '0);
    end
  endtask

  // Entered #1 after a rising edge with ready expected high.
  task automatic run_op(
    input logic [2:0]   op,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input string        tag
  );
    int k;
    int low;
    ctl = op; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    ctl = 3'($urandom);
    model(op, x, y);
    if (op == 3'd5) begin
      k = 0; low = 0;
      while (!done && k < 40) begin
        if (!ready) low++;
        start = ($urandom_range(0, 2) == 0);
        @(posedge clk); #1;
        k++;
      end
      start = 1'b0;
      chk({tag, " latency"}, 64'(k), 64'd32);
      chk({tag, " busy"}, 64'(low), 64'd32);
    end else begin
      chk({tag, " done"}, 64'(done), 64'd1);
    end
    chk({tag, " res"}, 64'(res), 64'(m_res));
    chk({tag, " flags"}, 64'(fl), 64'(m_fl));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    int r;
    logic [3:0] fsave;
    logic [2:0] op;

    reset = 1'b1; start = 1'b0;
    ctl = '0; a = '0; b = '0;
    m_res = '0; m_fl = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst ready", 64'(ready), 64'd1);
    chk("rst done", 64'(done), 64'd0);
    chk("rst res", 64'(res), 64'd0);
    chk("rst flags", 64'(fl), 64'd0);

    run_op(3'd0, 32'h7FFF_FFFF, 32'h1, "add_ovf");
    chk("add_ovf k_res", 64'(res), 64'h8000_0000);
    chk("add_ovf k_fl", 64'(fl), 64'b1001);

    @(posedge clk); #1;
    chk("done pulse 1cyc", 64'(done), 64'd0);

    run_op(3'd1, 32'd5, 32'd5, "sub_eq");
    chk("sub_eq k_fl", 64'(fl), 64'b0110);
    run_op(3'd1, 32'd3, 32'd5, "sub_neg");
    chk("sub_neg k_res", 64'(res), 64'hFFFF_FFFE);
    chk("sub_neg k_fl", 64'(fl), 64'b1000);

    run_op(3'd0, 32'hFFFF_FFFF, 32'h1, "add_c");
    chk("add_c k_fl", 64'(fl), 64'b0110);
    run_op(3'd3, 32'hF0F0_0000, 32'h0000_0F0F, "orr");
    chk("orr k_res", 64'(res), 64'hF0F0_0F0F);
    chk("orr k_fl", 64'(fl), 64'b1000);

    run_op(3'd1, 32'd5, 32'd5, "sub_pre");
    run_op(3'd5, 32'h1234, 32'h10, "mul");
    chk("mul k_res", 64'(res), 64'h0001_2340);
    chk("mul k_fl", 64'(fl), 64'b0010);

    ctl = 3'd5; a = $urandom; b = $urandom;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst ready", 64'(ready), 64'd1);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst res", 64'(res), 64'd0);
    chk("midrst flags", 64'(fl), 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("midrst late done", 64'(dn), 64'd0);
    m_res = '0; m_fl = '0;

    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, "b2b add");
    run_op(3'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, "b2b and");
    run_op(3'd1, 32'h8000_0000, 32'h1, "b2b sub");
    fsave = fl;
    run_op(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, "rsv");
    chk("rsv k_res", 64'(res), 64'd0);
    chk("rsv k_fl", 64'(fl), 64'(fsave));

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 15);
      if (r < 2) op = 3'd5;
      else if (r == 15) op = 3'(6 + (i % 2));
      else op = 3'(r % 5);
      run_op(op, pick(), pick(), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
